ad7864_seq_ctrl: RTL and testbench
==================================

AD7864_SEQ_CTRL -- requirements
Module: ad7864_seq_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CONV_LOW, 4, ad_conv_bar low width in clkin cycles (1..15).
- RD_LOW, 3, ad_rd_bar low width in clkin cycles (1..15).
- BUSY_TMO, 255, max clkin cycles from conversion start to ad_busy fall (8-bit).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clkin  in  1  sole clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- dsp_conv_bar  in  1  DSP conversion request, active-low, asynchronous to clkin.
- nch  in  2  channels to read per conversion, minus 1 (0..3 = 1..4 channels).
- ad_conv_bar  out  1  AD7864 CONVST, active-low.
- ad_busy  in  1  AD7864 BUSY, active-high, asynchronous.
- ad_cs_bar  out  1  AD7864 chip select, active-low.
- ad_rd_bar  out  1  AD7864 read strobe, active-low.
- ad_db  in  12  AD7864 data bus.
- smp_data  out  12  captured sample.
- smp_ch  out  2  channel index of smp_data.
- smp_valid  out  1  sample available.
- smp_ready  in  1  downstream accepts sample.
- active  out  1  high whenever state is not IDLE.
- overrun  out  1  sticky: request dropped.
- timeout  out  1  sticky: ad_busy never fell.
- clr_err  in  1  clears overrun and timeout.

Function
REQ-003 dsp_conv_bar and ad_busy SHALL each pass through a 2-flop synchronizer; a request is a synchronized 1->0 transition of dsp_conv_bar.
REQ-004 States SHALL be IDLE, CONV, WAIT_HI, WAIT_LO, RD_LOW_ST, RD_HOLD, PUSH.
REQ-005 IDLE: on request, go to CONV, clear channel counter, load CONV_LOW into the width counter.
REQ-006 CONV: ad_conv_bar low for exactly CONV_LOW cycles, then WAIT_HI.
REQ-007 WAIT_HI: go to WAIT_LO when synchronized busy is 1; WAIT_LO: go to RD_LOW_ST when synchronized busy is 0.
REQ-008 ad_cs_bar SHALL be low from entry to RD_LOW_ST of channel 0 until exit from PUSH of the last channel (nch, sampled at request time).
REQ-009 RD_LOW_ST: ad_rd_bar low for RD_LOW cycles; ad_db captured on the last low cycle; ad_rd_bar rises entering RD_HOLD (1 cycle high), then PUSH.
REQ-010 PUSH: if smp_valid=0, or smp_valid=1 and smp_ready=1 in the same cycle, load smp_data/smp_ch, set smp_valid, advance; otherwise stall in PUSH with ad_rd_bar high.
REQ-011 After PUSH: channel counter < nch -> increment, RD_LOW_ST; else IDLE with ad_cs_bar high.
REQ-012 smp_valid SHALL clear on smp_ready=1 unless reloaded the same cycle; smp_data/smp_ch stable while smp_valid=1 and smp_ready=0.
REQ-013 A request detected in any state other than IDLE SHALL be dropped and set overrun; it SHALL NOT restart the sequence.
REQ-014 Request and clr_err in the same cycle: set wins.
REQ-015 Channel counter SHALL NOT wrap; nch=3 yields exactly 4 samples, ch 0,1,2,3 in order.

Reset
REQ-016 rst high SHALL immediately force IDLE, ad_conv_bar=1, ad_cs_bar=1, ad_rd_bar=1, smp_valid=0, smp_data=0, smp_ch=0, active=0, overrun=0, timeout=0, synchronizers to idle levels (dsp_conv_bar 1, busy 0).
REQ-017 rst asserted mid-read SHALL abort without emitting a partial sample; first request after rst release starts a fresh sequence.

Configuration
REQ-018 With AD7864_TMO_WATCHDOG_EN defined: a cycle counter starts on CONV entry; if WAIT_HI/WAIT_LO not left within BUSY_TMO cycles, set timeout, drive ad_cs_bar/ad_conv_bar high, go IDLE, emit no samples.
REQ-019 Without AD7864_TMO_WATCHDOG_EN: no watchdog logic, WAIT_HI/WAIT_LO wait indefinitely, timeout tied 0.

Verification
REQ-020 nch=3, busy pulses 1 cycle after conv, ad_db=0x5D2 then +1 per read, smp_ready=1 -> ad_conv_bar low 4 cycles, 4 rd pulses 3 cycles each, samples 0x5D2..0x5D5 ch 0..3, cs low for whole read.
REQ-021 nch=1, smp_ready=0 for 20 cycles after first sample -> stall in PUSH, ad_rd_bar high, smp_data held, second sample after smp_ready rises, active=1 throughout.
REQ-022 Second request during WAIT_LO -> overrun=1, only one sequence of samples; clr_err pulse -> overrun=0.
REQ-023 ad_busy held 0 with watchdog enabled, BUSY_TMO=255 -> timeout=1 within 255 cycles of conv, state IDLE, no smp_valid.
REQ-024 rst pulse during second RD_LOW_ST of nch=3 -> all outputs at reset values next cycle; next request yields 4 clean samples ch 0..3.

Source files
------------

// File: rtl/ad7864_seq_ctrl.sv
// AD7864 conversion/read sequencer: CONVST pulse, BUSY wait, per-channel RD strobes, valid/ready sample output.
// Optional BUSY watchdog is enabled by defining AD7864_TMO_WATCHDOG_EN.
module ad7864_seq_ctrl #(
  parameter int CONV_LOW = 4,
  parameter int RD_LOW   = 3,
  parameter int BUSY_TMO = 255
) (
  input  logic        clkin,
  input  logic        rst,
  input  logic        dsp_conv_bar,
  input  logic [1:0]  nch,
  output logic        ad_conv_bar,
  input  logic        ad_busy,
  output logic        ad_cs_bar,
  output logic        ad_rd_bar,
  input  logic [11:0] ad_db,
  output logic [11:0] smp_data,
  output logic [1:0]  smp_ch,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic        active,
  output logic        overrun,
  output logic        timeout,
  input  logic        clr_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONV      = 3'd1,
    WAIT_HI   = 3'd2,
    WAIT_LO   = 3'd3,
    RD_LOW_ST = 3'd4,
    RD_HOLD   = 3'd5,
    PUSH      = 3'd6
  } state_t;

  localparam logic [3:0] CONV_W = 4'(CONV_LOW);
  localparam logic [3:0] RD_W   = 4'(RD_LOW);

  if (CONV_LOW < 1 || CONV_LOW > 15 || RD_LOW < 1 || RD_LOW > 15 ||
      BUSY_TMO < 1 || BUSY_TMO > 255) begin : g_param_err
    $error("ad7864_seq_ctrl: parameter out of range");
  end

  // FSM state is a named signal so checkers can bind to it directly.
  state_t      state, state_n;
  logic [3:0]  wcnt, wcnt_n;
  logic [1:0]  ch, ch_n;
  logic [1:0]  nch_q, nch_q_n;
  logic [11:0] cap, cap_n;
  logic [11:0] smp_data_n;
  logic [1:0]  smp_ch_n;
  logic        smp_valid_n;
  logic        overrun_n;

  logic [1:0]  dsp_sync;
  logic        dsp_prev;
  logic [1:0]  busy_sync;
  logic        busy_s;
  logic        req;
  logic        push_ok;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      dsp_sync  <= 2'b11;
      dsp_prev  <= 1'b1;
      busy_sync <= 2'b00;
    end else begin
      dsp_sync  <= {dsp_sync[0], dsp_conv_bar};
      dsp_prev  <= dsp_sync[1];
      busy_sync <= {busy_sync[0], ad_busy};
    end
  end

  assign busy_s = busy_sync[1];
  assign req    = dsp_prev & ~dsp_sync[1];

  // Sample handshake: a sample transfers on a clock edge where smp_valid and
  // smp_ready are both high; smp_data/smp_ch hold while valid waits for ready,
  // and a new sample may be loaded in the same cycle the old one is taken.
  assign push_ok = ~smp_valid | smp_ready;

`ifdef AD7864_TMO_WATCHDOG_EN
  localparam logic [7:0] TMO_LAST = 8'(BUSY_TMO - 1);
  logic [7:0] tmo_cnt, tmo_cnt_n;
  logic       timeout_n;
`endif

  always_comb begin
    state_n     = state;
    wcnt_n      = wcnt;
    ch_n        = ch;
    nch_q_n     = nch_q;
    cap_n       = cap;
    smp_data_n  = smp_data;
    smp_ch_n    = smp_ch;
    smp_valid_n = smp_valid & ~smp_ready;
    overrun_n   = overrun & ~clr_err;
    if (req && (state != IDLE)) overrun_n = 1'b1;

    case (state)
      IDLE: begin
        if (req) begin
          state_n = CONV;
          ch_n    = 2'd0;
          nch_q_n = nch;
          wcnt_n  = CONV_W;
        end
      end
      CONV: begin
        if (wcnt <= 4'd1) state_n = WAIT_HI;
        else              wcnt_n  = wcnt - 4'd1;
      end
      WAIT_HI: begin
        if (busy_s) state_n = WAIT_LO;
      end
      WAIT_LO: begin
        if (!busy_s) begin
          state_n = RD_LOW_ST;
          wcnt_n  = RD_W;
        end
      end
      RD_LOW_ST: begin
        if (wcnt <= 4'd1) begin
          cap_n   = ad_db;
          state_n = RD_HOLD;
        end else begin
          wcnt_n = wcnt - 4'd1;
        end
      end
      RD_HOLD: state_n = PUSH;
      PUSH: begin
        if (push_ok) begin
          smp_data_n  = cap;
          smp_ch_n    = ch;
          smp_valid_n = 1'b1;
          if (ch < nch_q) begin
            ch_n    = ch + 2'd1;
            wcnt_n  = RD_W;
            state_n = RD_LOW_ST;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef AD7864_TMO_WATCHDOG_EN
    tmo_cnt_n = tmo_cnt;
    timeout_n = timeout & ~clr_err;
    if ((state == IDLE) && req) begin
      tmo_cnt_n = 8'd0;
    end else if (((state == CONV) || (state == WAIT_HI) || (state == WAIT_LO)) &&
                 (tmo_cnt != 8'hFF)) begin
      tmo_cnt_n = tmo_cnt + 8'd1;
    end
    // Leaving the wait on the final allowed cycle still counts as in time.
    if (((state == WAIT_HI) || (state == WAIT_LO)) && (state_n == state) &&
        (tmo_cnt >= TMO_LAST)) begin
      timeout_n = 1'b1;
      state_n   = IDLE;
    end
`endif
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wcnt        <= 4'd0;
      ch          <= 2'd0;
      nch_q       <= 2'd0;
      cap         <= 12'd0;
      smp_data    <= 12'd0;
      smp_ch      <= 2'd0;
      smp_valid   <= 1'b0;
      overrun     <= 1'b0;
      ad_conv_bar <= 1'b1;
      ad_cs_bar   <= 1'b1;
      ad_rd_bar   <= 1'b1;
      active      <= 1'b0;
    end else begin
      state       <= state_n;
      wcnt        <= wcnt_n;
      ch          <= ch_n;
      nch_q       <= nch_q_n;
      cap         <= cap_n;
      smp_data    <= smp_data_n;
      smp_ch      <= smp_ch_n;
      smp_valid   <= smp_valid_n;
      overrun     <= overrun_n;
      // Strobes are decoded from the next state so they register glitch-free.
      ad_conv_bar <= (state_n != CONV);
      ad_cs_bar   <= !((state_n == RD_LOW_ST) || (state_n == RD_HOLD) || (state_n == PUSH));
      ad_rd_bar   <= (state_n != RD_LOW_ST);
      active      <= (state_n != IDLE);
    end
  end

`ifdef AD7864_TMO_WATCHDOG_EN
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 8'd0;
      timeout <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_n;
      timeout <= timeout_n;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ad7864_seq_ctrl.sv
// Bench for ad7864_seq_ctrl: vector table of read sequences plus stall, overrun, reset-abort and watchdog cases.
module tb_ad7864_seq_ctrl;

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        dsp_conv_bar = 1'b1;
  logic [1:0]  nch = 2'd0;
  logic        ad_conv_bar;
  logic        ad_busy = 1'b0;
  logic        ad_cs_bar;
  logic        ad_rd_bar;
  logic [11:0] ad_db;
  logic [11:0] smp_data;
  logic [1:0]  smp_ch;
  logic        smp_valid;
  logic        smp_ready = 1'b1;
  logic        active;
  logic        overrun;
  logic        timeout;
  logic        clr_err = 1'b0;

  ad7864_seq_ctrl dut (
    .clkin(clkin), .rst(rst), .dsp_conv_bar(dsp_conv_bar), .nch(nch),
    .ad_conv_bar(ad_conv_bar), .ad_busy(ad_busy), .ad_cs_bar(ad_cs_bar),
    .ad_rd_bar(ad_rd_bar), .ad_db(ad_db), .smp_data(smp_data), .smp_ch(smp_ch),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .active(active),
    .overrun(overrun), .timeout(timeout), .clr_err(clr_err)
  );

  // clock / reset
  always #5 clkin = ~clkin;

  // ADC model: BUSY one cycle after CONVST falls, data steps +1 per RD rise
  logic        busy_en = 1'b1;
  logic [11:0] rd_cnt = 12'd0;
  logic [11:0] db_base = 12'd0;
  assign ad_db = 12'(db_base + rd_cnt);

  always @(posedge ad_rd_bar) if (!rst) rd_cnt <= rd_cnt + 12'd1;

  always begin
    @(negedge ad_conv_bar);
    if (!rst && busy_en) begin
      @(posedge clkin); #1 ad_busy = 1'b1;
      repeat (20) @(posedge clkin);
      #1 ad_busy = 1'b0;
    end
  end

  // monitor
  logic [11:0] got_data[$];
  logic [1:0]  got_ch[$];
  int conv_lens[$];
  int rd_lens[$];
  int conv_run = 0, rd_run = 0, cs_falls = 0, rd_falls = 0;
  int proto_err = 0, hold_err = 0, ovr_hi_cnt = 0;
  logic prev_cs = 1'b1, prev_rd = 1'b1, prev_stall = 1'b0;
  logic [11:0] prev_data = 12'd0;
  logic [1:0]  prev_ch = 2'd0;

  always @(negedge clkin) begin
    if (rst) begin
      conv_run   <= 0;
      rd_run     <= 0;
      prev_cs    <= 1'b1;
      prev_rd    <= 1'b1;
      prev_stall <= 1'b0;
    end else begin
      if (smp_valid && smp_ready) begin
        got_data.push_back(smp_data);
        got_ch.push_back(smp_ch);
      end
      if (prev_stall && (!smp_valid || smp_data !== prev_data || smp_ch !== prev_ch))
        hold_err <= hold_err + 1;
      prev_stall <= smp_valid && !smp_ready;
      prev_data  <= smp_data;
      prev_ch    <= smp_ch;
      if (!ad_conv_bar) conv_run <= conv_run + 1;
      else if (conv_run != 0) begin conv_lens.push_back(conv_run); conv_run <= 0; end
      if (!ad_rd_bar) rd_run <= rd_run + 1;
      else if (rd_run != 0) begin rd_lens.push_back(rd_run); rd_run <= 0; end
      if (prev_cs && !ad_cs_bar) cs_falls <= cs_falls + 1;
      if (prev_rd && !ad_rd_bar) rd_falls <= rd_falls + 1;
      if ((!ad_rd_bar && ad_cs_bar) || (!ad_conv_bar && !ad_cs_bar)) proto_err <= proto_err + 1;
      if (overrun) ovr_hi_cnt <= ovr_hi_cnt + 1;
      prev_cs <= ad_cs_bar;
      prev_rd <= ad_rd_bar;
    end
  end

  // scoreboard
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_conv"}, ad_conv_bar, 1);
    check({tag, "_cs"}, ad_cs_bar, 1);
    check({tag, "_rd"}, ad_rd_bar, 1);
    check({tag, "_valid"}, smp_valid, 0);
    check({tag, "_data"}, smp_data, 0);
    check({tag, "_ch"}, smp_ch, 0);
    check({tag, "_active"}, active, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  // drivers
  task automatic send_req();
    @(posedge clkin); #1 dsp_conv_bar = 1'b0;
    repeat (3) @(posedge clkin);
    #1 dsp_conv_bar = 1'b1;
  endtask

  task automatic wait_active(input logic lvl, input int budget, input string name);
    int n = 0;
    @(negedge clkin);
    while (active !== lvl && n < budget) begin @(negedge clkin); n++; end
    check(name, active, lvl);
  endtask

  task automatic setup(input logic [1:0] nch_v, input logic [11:0] base);
    @(posedge clkin); #1 nch = nch_v;
    db_base = 12'(base - rd_cnt);
  endtask

  task automatic run_vec(input logic [1:0] nch_v, input logic [11:0] base,
                         input int exp_n, input logic [11:0] exp_last, input string tag);
    int d0 = got_data.size();
    int c0 = conv_lens.size();
    int r0 = rd_lens.size();
    int cf0 = cs_falls;
    int pe0 = proto_err;
    setup(nch_v, base);
    for (int i = 0; i <= int'(nch_v); i++) exp_q.push_back(12'(base + 12'(i)));
    send_req();
    wait_active(1'b1, 20, {tag, "_start"});
    wait_active(1'b0, 400, {tag, "_done"});
    repeat (3) @(negedge clkin);
    check({tag, "_nsamp"}, got_data.size() - d0, exp_n);
    for (int i = 0; i < exp_n && d0 + i < got_data.size(); i++) begin
      check({tag, "_data"}, got_data[d0 + i], exp_q.pop_front());
      check({tag, "_ch"}, got_ch[d0 + i], i);
    end
    exp_q.delete();
    if (got_data.size() > d0) check({tag, "_last"}, got_data[got_data.size() - 1], exp_last);
    check({tag, "_nconv"}, conv_lens.size() - c0, 1);
    if (conv_lens.size() > c0) check({tag, "_conv_len"}, conv_lens[c0], 4);
    check({tag, "_nrd"}, rd_lens.size() - r0, exp_n);
    for (int i = r0; i < rd_lens.size(); i++) check({tag, "_rd_len"}, rd_lens[i], 3);
    check({tag, "_cs_once"}, cs_falls - cf0, 1);
    check({tag, "_proto"}, proto_err - pe0, 0);
    check({tag, "_cs_idle"}, ad_cs_bar, 1);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  typedef struct {
    logic [1:0]  nch;
    logic [11:0] db_start;
    int          exp_n;
    logic [11:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0, r0, c0, h0, o0, rf0, n;
    vecs[0] = '{2'd3, 12'h5D2, 4, 12'h5D5};
    vecs[1] = '{2'd0, 12'h123, 1, 12'h123};
    vecs[2] = '{2'd1, 12'hFFF, 2, 12'h000};
    vecs[3] = '{2'd2, 12'hABC, 3, 12'hABE};
    vecs[4] = '{2'd3, 12'h000, 4, 12'h003};

    @(negedge clkin);
    check_reset_outputs("reset");
    repeat (3) @(posedge clkin);
    #1 rst = 1'b0;
    repeat (4) @(negedge clkin);
    check("idle_active", active, 0);

    for (int v = 0; v < 5; v++)
      run_vec(vecs[v].nch, vecs[v].db_start, vecs[v].exp_n, vecs[v].exp_last, $sformatf("vec%0d", v));

    // stall in PUSH with smp_ready low
    d0 = got_data.size(); r0 = rd_lens.size(); h0 = hold_err;
    @(posedge clkin); #1 smp_ready = 1'b0;
    setup(2'd1, 12'h0A0);
    send_req();
    n = 0;
    while (!smp_valid && n < 200) begin @(negedge clkin); n++; end
    check("stall_first_valid", smp_valid, 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clkin);
      check("stall_data", smp_data, 12'h0A0);
      check("stall_ch", smp_ch, 0);
      check("stall_valid", smp_valid, 1);
      check("stall_active", active, 1);
      if (k >= 8) check("stall_rd_high", ad_rd_bar, 1);
    end
    check("stall_two_reads", rd_lens.size() - r0, 2);
    @(posedge clkin); #1 smp_ready = 1'b1;
    wait_active(1'b0, 100, "stall_done");
    repeat (3) @(negedge clkin);
    check("stall_nsamp", got_data.size() - d0, 2);
    if (got_data.size() - d0 == 2) begin
      check("stall_s0", got_data[d0], 12'h0A0);
      check("stall_s1", got_data[d0 + 1], 12'h0A1);
      check("stall_c1", got_ch[d0 + 1], 1);
    end
    check("stall_hold", hold_err - h0, 0);

    // second request during WAIT_LO is dropped and flagged
    check("ovr_pre", overrun, 0);
    d0 = got_data.size(); c0 = conv_lens.size();
    setup(2'd0, 12'h300);
    send_req();
    n = 0;
    while (ad_conv_bar && n < 20) begin @(negedge clkin); n++; end
    while (!ad_conv_bar && n < 40) begin @(negedge clkin); n++; end
    check("ovr_conv_seen", ad_conv_bar, 1);
    repeat (4) @(posedge clkin);
    send_req();
    wait_active(1'b0, 400, "ovr_done");
    repeat (10) @(negedge clkin);
    check("ovr_set", overrun, 1);
    check("ovr_nsamp", got_data.size() - d0, 1);
    if (got_data.size() > d0) check("ovr_data", got_data[d0], 12'h300);
    check("ovr_nconv", conv_lens.size() - c0, 1);
    @(posedge clkin); #1 clr_err = 1'b1;
    @(posedge clkin); #1 clr_err = 1'b0;
    @(negedge clkin);
    check("ovr_clr", overrun, 0);

    // request and clr_err together: the set survives for one cycle
    o0 = ovr_hi_cnt;
    @(posedge clkin); #1 clr_err = 1'b1;
    setup(2'd0, 12'h310);
    send_req();
    n = 0;
    while (ad_conv_bar && n < 20) begin @(negedge clkin); n++; end
    while (!ad_conv_bar && n < 40) begin @(negedge clkin); n++; end
    repeat (4) @(posedge clkin);
    send_req();
    wait_active(1'b0, 400, "setwin_done");
    repeat (3) @(negedge clkin);
    check("setwin_pulse", ovr_hi_cnt - o0, 1);
    @(posedge clkin); #1 clr_err = 1'b0;

    // reset during the second RD low phase of a 4-channel read
    d0 = got_data.size(); rf0 = rd_falls;
    setup(2'd3, 12'h7F0);
    send_req();
    n = 0;
    while (rd_falls != rf0 + 2 && n < 400) begin @(negedge clkin); n++; end
    check("rstmid_second_rd", rd_falls - rf0, 2);
    check("rstmid_rd_low", ad_rd_bar, 0);
    #1 rst = 1'b1;
    #1 check_reset_outputs("rstmid");
    repeat (2) @(posedge clkin);
    #1 rst = 1'b0;
    repeat (3) @(negedge clkin);
    check("rstmid_nsamp", got_data.size() - d0, 1);
    check_reset_outputs("rstmid_after");
    run_vec(2'd3, 12'h040, 4, 12'h043, "rstmid_fresh");

`ifdef AD7864_TMO_WATCHDOG_EN
    d0 = got_data.size();
    busy_en = 1'b0;
    setup(2'd0, 12'h111);
    send_req();
    n = 0;
    while (ad_conv_bar && n < 20) begin @(negedge clkin); n++; end
    check("tmo_conv", ad_conv_bar, 0);
    n = 0;
    while (!timeout && n < 300) begin @(negedge clkin); n++; end
    check("tmo_set", timeout, 1);
    check("tmo_latency_ok", (n >= 250 && n <= 255), 1);
    check("tmo_idle", active, 0);
    check("tmo_cs", ad_cs_bar, 1);
    check("tmo_conv_hi", ad_conv_bar, 1);
    repeat (5) @(negedge clkin);
    check("tmo_nsamp", got_data.size() - d0, 0);
    check("tmo_valid", smp_valid, 0);
    @(posedge clkin); #1 clr_err = 1'b1;
    @(posedge clkin); #1 clr_err = 1'b0;
    @(negedge clkin);
    check("tmo_clr", timeout, 0);
    busy_en = 1'b1;
`else
    check("no_wdog_timeout", timeout, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
